// File: rtl/mem_arbiter_2core.sv
// mem_arbiter_2core
// Shares one single-port synchronous data memory between two processor cores.
// Each access runs IDLE -> ISSUE -> WAIT -> ACK -> IDLE. Only one access is in
// flight at a time. When both cores request, the winner is chosen round-robin.
// All memory-side outputs, read-data and counters come from flops. There is no
// combinational path from mem_rdata to any output.
//
// Ports
//   clk                       clock; all logic updates on posedge
//   resetn                    synchronous reset, active-high (1 = reset)
//   read_k / write_k          core k request; write wins if both are high
//   address_k / write_data_k  core k address and write data, held while requesting
//   fetched_data_k            last read result returned to core k
//   stall_cpu_k               1 while core k's request is still outstanding
//   mem_en / mem_we           one-cycle access strobe and its write qualifier
//   mem_addr / mem_wdata      address and write data, valid with mem_en
//   mem_rdata                 read data, valid MEM_LAT cycles after mem_en
//   served_cnt_k              number of completed accesses for core k; wraps to 0

module mem_arbiter_2core #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int ACK_HOLD = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              read_0,
    input  logic              read_1,
    input  logic              write_0,
    input  logic              write_1,
    input  logic [ADDR_W-1:0] address_0,
    input  logic [ADDR_W-1:0] address_1,
    input  logic [DATA_W-1:0] write_data_0,
    input  logic [DATA_W-1:0] write_data_1,
    output logic [DATA_W-1:0] fetched_data_0,
    output logic [DATA_W-1:0] fetched_data_1,
    output logic              stall_cpu_0,
    output logic              stall_cpu_1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  served_cnt_0,
    output logic [CNT_W-1:0]  served_cnt_1
);

    localparam int ACK_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

    state_e              state_q;
    logic                owner_q;
    logic                rr_ptr_q;
    logic                op_we_q;
    logic [2:0]          lat_cnt_q;
    logic [ACK_W-1:0]    ack_cnt_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   fetched_0_q;
    logic [DATA_W-1:0]   fetched_1_q;
    logic [CNT_W-1:0]    served_0_q;
    logic [CNT_W-1:0]    served_1_q;

    logic req_0, req_1;
    logic grant_d;

    assign req_0 = read_0 | write_0;
    assign req_1 = read_1 | write_1;

    // Contention goes to rr_ptr; otherwise the single requester wins.
    always_comb begin
        grant_d = 1'b0;
        if (req_0 && req_1) grant_d = rr_ptr_q;
        else                grant_d = req_1;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            op_we_q     <= 1'b0;
            lat_cnt_q   <= '0;
            ack_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fetched_0_q <= '0;
            fetched_1_q <= '0;
            served_0_q  <= '0;
            served_1_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_0 || req_1) begin
                        // The memory-side registers double as the request latch.
                        owner_q     <= grant_d;
                        op_we_q     <= grant_d ? write_1 : write_0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_d ? write_1 : write_0;
                        mem_addr_q  <= grant_d ? address_1 : address_0;
                        mem_wdata_q <= grant_d ? write_data_1 : write_data_0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    lat_cnt_q <= 3'(MEM_LAT - 1);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt_q == '0) begin
                        if (!op_we_q) begin
                            if (owner_q) fetched_1_q <= mem_rdata;
                            else         fetched_0_q <= mem_rdata;
                        end
                        if (owner_q) served_1_q <= served_1_q + CNT_W'(1);
                        else         served_0_q <= served_0_q + CNT_W'(1);
                        ack_cnt_q <= ACK_W'(ACK_HOLD - 1);
                        state_q   <= ACK;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                ACK: begin
                    if (ack_cnt_q == '0) begin
                        rr_ptr_q <= ~owner_q;
                        state_q  <= IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - ACK_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Masking with ~resetn keeps stall equal to the request while reset is held,
    // even in the cycle reset arrives during ACK.
    assign stall_cpu_0 = req_0 & ~((state_q == ACK) & ~owner_q & ~resetn);
    assign stall_cpu_1 = req_1 & ~((state_q == ACK) &  owner_q & ~resetn);

    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign fetched_data_0 = fetched_0_q;
    assign fetched_data_1 = fetched_1_q;
    assign served_cnt_0   = served_0_q;
    assign served_cnt_1   = served_1_q;

endmodule
